// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage with IF/DE pipeline register. Owns the
//               PC, drives a synchronous-read instruction memory, applies the
//               hazard unit's stall/flush/redirect controls and presents the
//               decode-stage instruction and its register fields.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 STALL,
    input  logic                 FLUSH,
    input  logic [1:0]           PC_SEL,
    input  logic [XLEN-1:0]      JALR_TGT,
    input  logic [XLEN-1:0]      BR_TGT,
    input  logic [XLEN-1:0]      JAL_TGT,
    output logic [XLEN-1:0]      IMEM_ADDR,
    output logic                 IMEM_EN,
    input  logic [31:0]          IMEM_RDATA,
    output logic [XLEN-1:0]      D_PC,
    output logic [XLEN-1:0]      D_PC4,
    output logic [31:0]          D_IR,
    output logic                 D_VALID,
    output logic [6:0]           D_OP,
    output logic [4:0]           D_ADDR1,
    output logic [4:0]           D_ADDR2,
    output logic [4:0]           D_WADDR
);

    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~(XLEN'(3));

    localparam logic [1:0] c_SEL_SEQ  = 2'b00;
    localparam logic [1:0] c_SEL_JALR = 2'b01;
    localparam logic [1:0] c_SEL_BR   = 2'b10;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_dpc;
    logic            r_valid;
    logic [31:0]     r_hold;
    logic            r_hold_v;

    logic [XLEN-1:0] w_pc_src;
    logic [XLEN-1:0] w_next_pc;
    logic            w_redirect;
    logic [31:0]     w_raw_ir;

    // Next-PC mux; targets are word-aligned by masking the two low bits.
    always_comb begin
        w_pc_src = r_pc + c_PC_STEP;
        case (PC_SEL)
            c_SEL_SEQ:  w_pc_src = r_pc + c_PC_STEP;
            c_SEL_JALR: w_pc_src = JALR_TGT;
            c_SEL_BR:   w_pc_src = BR_TGT;
            default:    w_pc_src = JAL_TGT;
        endcase
    end

    assign w_next_pc  = w_pc_src & c_ALIGN_MASK;
    assign w_redirect = (PC_SEL != c_SEL_SEQ);

    // PC and IF/DE register; a stall freezes everything and captures the
    // instruction that was on the memory bus so it survives IMEM going idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc     <= RESET_PC;
            r_dpc    <= RESET_PC;
            r_valid  <= 1'b0;
            r_hold   <= NOP_INSTR;
            r_hold_v <= 1'b0;
        end else if (STALL) begin
            if (!r_hold_v) begin
                r_hold   <= IMEM_RDATA;
                r_hold_v <= 1'b1;
            end
        end else begin
            r_pc     <= w_next_pc;
            r_dpc    <= r_pc;
            r_valid  <= !(FLUSH || w_redirect);
            r_hold_v <= 1'b0;
        end
    end

    assign IMEM_ADDR = r_pc;
    assign IMEM_EN   = RST_N && !STALL;

    // Decode-side view: held copy while a stall is in progress, bubble when
    // the slot is not a real instruction.
    assign w_raw_ir = r_hold_v ? r_hold : IMEM_RDATA;
    assign D_IR     = r_valid ? w_raw_ir : NOP_INSTR;
    assign D_VALID  = r_valid;
    assign D_PC     = r_dpc;
    assign D_PC4    = r_dpc + c_PC_STEP;
    assign D_OP     = D_IR[6:0];
    assign D_ADDR1  = D_IR[19:15];
    assign D_ADDR2  = D_IR[24:20];
    assign D_WADDR  = D_IR[11:7];

endmodule
`default_nettype wire
